mem_arbiter: RTL

Two-requester arbiter that shares the single-port synchronous memory between the CPU (requester 0) and a loader/debug port (requester 1, e.g. a program loader driven from io_input).
- Sits between the requesters and the memory instance; drives the memory's address, write-data and write-enable lines.
- Routes memory read data back to the requester that issued the read.
- Uses round-robin priority, with an optional lock for atomic multi-access sequences.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_rd_tracker.sv | 77 +++++++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-requester memory arbiter.
// No logic; types and constants only.
// Imported by mem_arbiter and mem_rd_tracker.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED0  = 2'd1,
      LOCKED1  = 2'd2
   } lock_state_e;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mem_rd_tracker.sv
// Tracks in-flight reads and steers memory read data to the requester that issued each one.
// Latency: rvalid/rdata appear MEM_LATENCY edges after the edge that completed the read.
// Backpressure: none; one entry per cycle, responses cannot be stalled.
module mem_rd_tracker
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  issue_vld,
   input  logic                  issue_owner,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  r0_rvalid,
   output logic [DATA_WIDTH-1:0] r0_rdata,
   output logic                  r1_rvalid,
   output logic [DATA_WIDTH-1:0] r1_rdata
);

   logic [MEM_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
   logic [MEM_LATENCY-1:0] pipe_own_q, pipe_own_d;
   logic                   r0_rvalid_q, r0_rvalid_d;
   logic                   r1_rvalid_q, r1_rvalid_d;
   logic [DATA_WIDTH-1:0]  r0_rdata_q, r0_rdata_d;
   logic [DATA_WIDTH-1:0]  r1_rdata_q, r1_rdata_d;
   logic                   exit_vld;
   logic                   exit_own;

   // Shift the {valid, owner} tag one stage per cycle, new read enters stage 0.
   always_comb begin
      pipe_vld_d    = '0;
      pipe_own_d    = '0;
      pipe_vld_d[0] = issue_vld;
      pipe_own_d[0] = issue_owner;
      for (int i = 1; i < MEM_LATENCY; i++) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         pipe_own_d[i] = pipe_own_q[i-1];
      end
   end

   assign exit_vld = pipe_vld_q[MEM_LATENCY-1];
   assign exit_own = pipe_own_q[MEM_LATENCY-1];

   // Capture memory data for the owner of the exiting tag; the other side holds its data.
   always_comb begin
      r0_rvalid_d = exit_vld && (exit_own == REQ0);
      r1_rvalid_d = exit_vld && (exit_own == REQ1);
      r0_rdata_d  = r0_rvalid_d ? mem_rdata : r0_rdata_q;
      r1_rdata_d  = r1_rvalid_d ? mem_rdata : r1_rdata_q;
   end

   // Tag pipeline and response registers; reset drops every in-flight read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld_q  <= '0;
         pipe_own_q  <= '0;
         r0_rvalid_q <= 1'b0;
         r1_rvalid_q <= 1'b0;
         r0_rdata_q  <= '0;
         r1_rdata_q  <= '0;
      end else begin
         pipe_vld_q  <= pipe_vld_d;
         pipe_own_q  <= pipe_own_d;
         r0_rvalid_q <= r0_rvalid_d;
         r1_rvalid_q <= r1_rvalid_d;
         r0_rdata_q  <= r0_rdata_d;
         r1_rdata_q  <= r1_rdata_d;
      end
   end

   assign r0_rvalid = r0_rvalid_q;
   assign r1_rvalid = r1_rvalid_q;
   assign r0_rdata  = r0_rdata_q;
   assign r1_rdata  = r1_rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between two requesters, with ownership lock.
// Latency: grant and memory drive are combinational in the request cycle; reads return via mem_rd_tracker.
// Backpressure: a requester holds req until gnt; a locked owner blocks the other requester.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  async_nreset,
   input  logic                  r0_req,
   input  logic                  r0_write,
   input  logic                  r0_lock,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   input  logic [DATA_WIDTH-1:0] r0_wdata,
   output logic                  r0_gnt,
   output logic                  r0_rvalid,
   output logic [DATA_WIDTH-1:0] r0_rdata,
   input  logic                  r1_req,
   input  logic                  r1_write,
   input  logic                  r1_lock,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [DATA_WIDTH-1:0] r1_wdata,
   output logic                  r1_gnt,
   output logic                  r1_rvalid,
   output logic [DATA_WIDTH-1:0] r1_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr_out,
   output logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  mem_write,
   input  logic [DATA_WIDTH-1:0] mem_data_in
);

   lock_state_e lock_q, lock_d;
   logic        ptr_q, ptr_d;
   logic        gnt0, gnt1;
   logic        issue_vld;
   logic        issue_owner;

   // Grant selection: lock owner only, else sole requester, else pointer; nothing while in reset.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (async_nreset) begin
         case (lock_q)
            LOCKED0: gnt0 = r0_req;
            LOCKED1: gnt1 = r1_req;
            default: begin
               if (r0_req && r1_req) begin
                  gnt0 = (ptr_q == REQ0);
                  gnt1 = (ptr_q == REQ1);
               end else begin
                  gnt0 = r0_req;
                  gnt1 = r1_req;
               end
            end
         endcase
      end
   end

   // Memory drive follows the granted requester and is zero when idle.
   always_comb begin
      mem_addr_out = '0;
      mem_data_out = '0;
      mem_write    = 1'b0;
      if (gnt0) begin
         mem_addr_out = r0_addr;
         mem_data_out = r0_wdata;
         mem_write    = r0_write;
      end else if (gnt1) begin
         mem_addr_out = r1_addr;
         mem_data_out = r1_wdata;
         mem_write    = r1_write;
      end
   end

   // Next pointer (moves to the loser on any grant) and lock state transitions.
   always_comb begin
      ptr_d  = ptr_q;
      lock_d = lock_q;
      if (gnt0) begin
         ptr_d = REQ1;
      end else if (gnt1) begin
         ptr_d = REQ0;
      end
      case (lock_q)
         UNLOCKED: begin
            if (gnt0 && r0_lock) begin
               lock_d = LOCKED0;
            end else if (gnt1 && r1_lock) begin
               lock_d = LOCKED1;
            end
         end
         LOCKED0: begin
            if ((gnt0 && !r0_lock) || (!r0_req && !r0_lock)) begin
               lock_d = UNLOCKED;
            end
         end
         LOCKED1: begin
            if ((gnt1 && !r1_lock) || (!r1_req && !r1_lock)) begin
               lock_d = UNLOCKED;
            end
         end
         default: lock_d = UNLOCKED;
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         ptr_q  <= REQ0;
         lock_q <= UNLOCKED;
      end else begin
         ptr_q  <= ptr_d;
         lock_q <= lock_d;
      end
   end

   assign r0_gnt      = gnt0;
   assign r1_gnt      = gnt1;
   assign issue_vld   = (gnt0 && !r0_write) || (gnt1 && !r1_write);
   assign issue_owner = gnt1 ? REQ1 : REQ0;

   mem_rd_tracker #(
      .DATA_WIDTH  (DATA_WIDTH),
      .MEM_LATENCY (MEM_LATENCY)
   ) u_rd_tracker (
      .clk         (clk),
      .rst_n       (async_nreset),
      .issue_vld   (issue_vld),
      .issue_owner (issue_owner),
      .mem_rdata   (mem_data_in),
      .r0_rvalid   (r0_rvalid),
      .r0_rdata    (r0_rdata),
      .r1_rvalid   (r1_rvalid),
      .r1_rdata    (r1_rdata)
   );

endmodule
